pipeline_hazard_ctrl: RTL

Central sequencer for the five-stage pipeline registers IF_ID, ID_EX, EX_MEM and MEM_WB.
- Each cycle it decides, per register, whether to advance, hold (stall) or load a bubble (reset_t = RESET_RESET).
- It arbitrates load-use hazards, taken-branch redirects and instruction/data memory wait states.
- A small FSM holds a pending redirect across a busy instruction fetch.

---
 rtl/pipes_pkg.sv | 17 +
 rtl/pipeline_hazard_ctrl_load_use.sv | 24 ++
 rtl/pipeline_hazard_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pipes_pkg.sv
// Shared pipeline types: register reset control and hazard sequencer state.
// Purely declarative; no latency or backpressure of its own.
package pipes;

    typedef enum logic {
        RESET_CONTINUE = 1'b0,
        RESET_RESET    = 1'b1
    } reset_t;

    typedef enum logic {
        RUN        = 1'b0,
        REDIR_HOLD = 1'b1
    } hz_state_t;

    localparam logic [63:0] PC_RESET_DEFAULT = 64'h8000_0000;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Load-use hazard detect: EX load whose destination feeds an ID source operand.
// Latency: combinational. Backpressure: none, pure function of register fields.
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             ex_is_load,
    input  logic             ex_regwrite,
    output logic             hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_use_rs1 && (id_rs1 == ex_dst);
    assign rs2_hit = id_use_rs2 && (id_rs2 == ex_dst);
    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign hazard  = ex_is_load && ex_regwrite && (ex_dst != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: per-register advance/hold/bubble, redirects, stall counter.
// Latency: control outputs combinational; pending redirect and counter registered.
// Backpressure: dmem_busy freezes the whole pipe; imem_busy holds PC and bubbles IF_ID.
module pipeline_hazard_ctrl
    import pipes::*;
#(
    parameter logic [63:0] PC_RESET = 64'h8000_0000,
    parameter int          REG_W    = 5,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             ex_is_load,
    input  logic             ex_regwrite,
    input  logic             ex_branch_taken,
    input  logic [63:0]      ex_target,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    output logic             stall_pc,
    output logic             stall_IF_ID,
    output logic             stall_ID_EX,
    output logic             stall_EX_MEM,
    output logic             stall_MEM_WB,
    output reset_t           reset_IF_ID,
    output reset_t           reset_ID_EX,
    output reset_t           reset_EX_MEM,
    output reset_t           reset_MEM_WB,
    output logic             redirect_valid,
    output logic [63:0]      redirect_pc,
    output logic [CNT_W-1:0] stall_cycles
);

    hz_state_t   state, nxt_state;
    logic [63:0] pend_pc, nxt_pend;
    logic        load_use;

    load_use_detect #(.REG_W(REG_W)) u_load_use (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_dst      (ex_dst),
        .ex_is_load  (ex_is_load),
        .ex_regwrite (ex_regwrite),
        .hazard      (load_use)
    );

    always_comb begin
        stall_pc       = 1'b0;
        stall_IF_ID    = 1'b0;
        stall_ID_EX    = 1'b0;
        stall_EX_MEM   = 1'b0;
        stall_MEM_WB   = 1'b0;
        reset_IF_ID    = RESET_CONTINUE;
        reset_ID_EX    = RESET_CONTINUE;
        reset_EX_MEM   = RESET_CONTINUE;
        reset_MEM_WB   = RESET_CONTINUE;
        redirect_valid = 1'b0;
        redirect_pc    = PC_RESET;
        nxt_state      = state;
        nxt_pend       = pend_pc;

        if (!reset) begin
            reset_IF_ID  = RESET_RESET;
            reset_ID_EX  = RESET_RESET;
            reset_EX_MEM = RESET_RESET;
            reset_MEM_WB = RESET_RESET;
        end else if (dmem_busy) begin
            // Full freeze; any branch in EX is re-evaluated once EX moves on
            stall_pc     = 1'b1;
            stall_IF_ID  = 1'b1;
            stall_ID_EX  = 1'b1;
            stall_EX_MEM = 1'b1;
            stall_MEM_WB = 1'b1;
        end else if (state == REDIR_HOLD) begin
            reset_IF_ID = RESET_RESET;
            if (ex_branch_taken)
                nxt_pend = ex_target;
            if (imem_busy) begin
                stall_pc = 1'b1;
            end else begin
                redirect_valid = 1'b1;
                redirect_pc    = pend_pc;
                nxt_state      = RUN;
            end
        end else if (ex_branch_taken) begin
            reset_IF_ID = RESET_RESET;
            reset_ID_EX = RESET_RESET;
            if (imem_busy) begin
                // Fetch in flight: park the target until the fetch returns
                stall_pc  = 1'b1;
                nxt_pend  = ex_target;
                nxt_state = REDIR_HOLD;
            end else begin
                redirect_valid = 1'b1;
                redirect_pc    = ex_target;
            end
        end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_IF_ID = 1'b1;
            reset_ID_EX = RESET_RESET;
        end else if (imem_busy) begin
            stall_pc    = 1'b1;
            reset_IF_ID = RESET_RESET;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            pend_pc      <= PC_RESET;
            stall_cycles <= '0;
        end else begin
            state   <= nxt_state;
            pend_pc <= nxt_pend;
            if (stall_pc)
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
